// File: rtl/mvm_tile_engine.sv
// Tiled signed matrix-vector engine: C[1xN] = A[1xK*LANES] * B, one LANES-wide dot product per B beat.
// Define MVM_SAT_EN for saturating accumulation and a sticky sat_flag output; the default build wraps.
module mvm_tile_engine #(
    parameter int LANES  = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int MAX_N  = 64,
    parameter int K_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             cfg_k,
    input  logic [$clog2(MAX_N+1)-1:0] cfg_n,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [LANES*DATA_W-1:0]    a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [LANES*DATA_W-1:0]    b_data,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [ACC_W-1:0]           c_data,
    output logic [$clog2(MAX_N)-1:0]   c_idx
`ifdef MVM_SAT_EN
    ,
    output logic                       sat_flag
`endif
);
    // state    | meaning
    // IDLE     | waiting for start; configuration checked here
    // LOAD_A   | accepting the A tile for tile kt
    // STREAM_B | one B beat per output column into the MAC pipeline
    // DRAIN    | in-flight accumulates land before acc is read again
    // OUT      | streaming acc[0..N-1] on the C port
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_A   = 3'd1;
    localparam logic [2:0] S_STREAM_B = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_OUT      = 3'd4;

    localparam int N_W    = $clog2(MAX_N+1);
    localparam int IDX_W  = $clog2(MAX_N);
    localparam int PROD_W = 2*DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

    logic [2:0]              state_q, state_d;
    logic [K_W-1:0]          cfg_k_q, cfg_k_d, kt_q, kt_d;
    logic [N_W-1:0]          cfg_n_q, cfg_n_d, n_q, n_d;
    logic                    drain_q, drain_d;
    logic                    err_q, err_d, done_q, done_d;
    logic                    s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
    logic [IDX_W-1:0]        s1_n_q, s1_n_d;
    logic [LANES*DATA_W-1:0] a_tile_q, a_tile_d;
    logic signed [PROD_W-1:0] s1_prod_q [LANES];
    logic signed [PROD_W-1:0] s1_prod_d [LANES];
    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] base;
    logic [ACC_W-1:0]        acc_wdata;
    logic [ACC_W-1:0]        acc_q [MAX_N];

`ifdef MVM_SAT_EN
    localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic signed [WIDE_W-1:0] ACC_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] ACC_MIN = ~ACC_MAX;
    logic signed [WIDE_W-1:0] wide;
    logic sat_hit, sat_q, sat_d;
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = PROD_W'($signed(a_tile_q[i*DATA_W +: DATA_W]))
                    * PROD_W'($signed(b_data[i*DATA_W +: DATA_W]));
        end
    end

    // Stage 2: the first tile overwrites acc, so no separate clear pass is needed.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUM_W'(s1_prod_q[i]);
        end
        base = s1_first_q ? '0 : $signed(acc_q[s1_n_q]);
`ifdef MVM_SAT_EN
        wide    = WIDE_W'(sum) + WIDE_W'(base);
        sat_hit = 1'b0;
        if (wide > ACC_MAX) begin
            acc_wdata = ACC_MAX[ACC_W-1:0];
            sat_hit   = 1'b1;
        end else if (wide < ACC_MIN) begin
            acc_wdata = ACC_MIN[ACC_W-1:0];
            sat_hit   = 1'b1;
        end else begin
            acc_wdata = wide[ACC_W-1:0];
        end
`else
        acc_wdata = base + ACC_W'(sum);
`endif
    end

    always_comb begin
        state_d    = state_q;
        cfg_k_d    = cfg_k_q;
        cfg_n_d    = cfg_n_q;
        kt_d       = kt_q;
        n_d        = n_q;
        drain_d    = drain_q;
        err_d      = err_q;
        done_d     = 1'b0;
        s1_valid_d = 1'b0;
        s1_first_d = s1_first_q;
        s1_n_d     = s1_n_q;
        s1_prod_d  = s1_prod_q;
        a_tile_d   = a_tile_q;
`ifdef MVM_SAT_EN
        sat_d      = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_k_d = cfg_k;
                    cfg_n_d = cfg_n;
`ifdef MVM_SAT_EN
                    sat_d   = 1'b0;
`endif
                    if (cfg_k == '0 || cfg_n == '0 || cfg_n > MAX_N_V) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        kt_d    = '0;
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                if (a_valid) begin
                    a_tile_d = a_data;
                    n_d      = '0;
                    state_d  = S_STREAM_B;
                end
            end
            S_STREAM_B: begin
                if (b_valid) begin
                    s1_valid_d = 1'b1;
                    s1_first_d = (kt_q == '0);
                    s1_n_d     = n_q[IDX_W-1:0];
                    s1_prod_d  = prod;
                    n_d        = n_q + N_W'(1);
                    if (n_q == cfg_n_q - N_W'(1)) begin
                        drain_d = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 1'b0) begin
                    if (kt_q == cfg_k_q - K_W'(1)) begin
                        n_d     = '0;
                        state_d = S_OUT;
                    end else begin
                        kt_d    = kt_q + K_W'(1);
                        state_d = S_LOAD_A;
                    end
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_OUT: begin
                if (c_ready) begin
                    n_d = n_q + N_W'(1);
                    if (n_q == cfg_n_q - N_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MVM_SAT_EN
        if (s1_valid_q && sat_hit) sat_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cfg_k_q    <= '0;
            cfg_n_q    <= '0;
            kt_q       <= '0;
            n_q        <= '0;
            drain_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
`ifdef MVM_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cfg_k_q    <= cfg_k_d;
            cfg_n_q    <= cfg_n_d;
            kt_q       <= kt_d;
            n_q        <= n_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
`ifdef MVM_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    // Datapath registers carry no reset; they are only consumed behind valid state.
    always_ff @(posedge clk) begin
        a_tile_q   <= a_tile_d;
        s1_first_q <= s1_first_d;
        s1_n_q     <= s1_n_d;
        s1_prod_q  <= s1_prod_d;
        if (s1_valid_q) acc_q[s1_n_q] <= acc_wdata;
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign a_ready = (state_q == S_LOAD_A);
    assign b_ready = (state_q == S_STREAM_B);
    assign c_valid = (state_q == S_OUT);
    assign c_idx   = c_valid ? n_q[IDX_W-1:0] : '0;
    assign c_data  = c_valid ? acc_q[n_q[IDX_W-1:0]] : '0;
`ifdef MVM_SAT_EN
    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_mvm_tile_engine.sv
// Self-checking bench for mvm_tile_engine: directed scenarios plus randomized runs against a dot-product model.
`timescale 1ns/1ps
module tb_mvm_tile_engine;
    localparam int L  = 8;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int MN = 64;
    localparam int KW = 8;
    localparam int NW = $clog2(MN+1);
    localparam int IW = $clog2(MN);
    localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint ACC_MIN = -ACC_MAX - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic [NW-1:0] cfg_n = '0;
    logic busy, done, err;
    logic a_valid = 1'b0, a_ready;
    logic [L*DW-1:0] a_data = '0;
    logic b_valid = 1'b0, b_ready;
    logic [L*DW-1:0] b_data = '0;
    logic c_valid, c_ready;
    logic [AW-1:0] c_data;
    logic [IW-1:0] c_idx;
`ifdef MVM_SAT_EN
    logic sat_flag;
`endif

    mvm_tile_engine #(.LANES(L), .DATA_W(DW), .ACC_W(AW), .MAX_N(MN), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .busy(busy), .done(done), .err(err),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_idx(c_idx)
`ifdef MVM_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_xfer = -10;
    int stall_obs = 0;
    int crdy_mode = 0;
    int stall_cnt = 0;
    bit exp_sat = 1'b0;
    longint exp_q[$];
    int exp_idx_q[$];
    longint got[MN];
    logic signed [DW-1:0] a_mem [4][L];
    logic signed [DW-1:0] b_mem [4][8][L];

    task automatic chk(input string name, input longint g, input longint e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, g, e, $time);
        end
    endtask

    // Reference: C[c] = sum over tiles of dot(A_t, B_t,c), each accumulate fitted to ACC_W.
    function automatic longint fit(input longint x);
`ifdef MVM_SAT_EN
        if (x > ACC_MAX) return ACC_MAX;
        if (x < ACC_MIN) return ACC_MIN;
        return x;
`else
        return (x <<< (64-AW)) >>> (64-AW);
`endif
    endfunction

    task automatic model_run(input int k, input int n);
        longint acc, dot;
        for (int c = 0; c < n; c++) begin
            acc = 0;
            for (int t = 0; t < k; t++) begin
                dot = 0;
                for (int i = 0; i < L; i++) dot += longint'(a_mem[t][i]) * longint'(b_mem[t][c][i]);
                if (acc + dot > ACC_MAX || acc + dot < ACC_MIN) exp_sat = 1'b1;
                acc = fit(acc + dot);
            end
            exp_q.push_back(acc);
            exp_idx_q.push_back(c);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        case (crdy_mode)
            1: c_ready = ($urandom_range(0, 1) == 1);
            2: begin
                if (stall_cnt > 0) begin
                    c_ready = 1'b0;
                    if (c_valid) stall_cnt--;
                end else c_ready = 1'b1;
            end
            default: c_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && c_valid) begin
            if (exp_q.size() == 0) chk("c_unexpected_idx", longint'(c_idx), -1);
            else begin
                chk("c_idx", longint'(c_idx), longint'(exp_idx_q[0]));
                chk("c_data", longint'($signed(c_data)), exp_q[0]);
                if (c_ready) begin
                    got[c_idx] = longint'($signed(c_data));
                    void'(exp_q.pop_front());
                    void'(exp_idx_q.pop_front());
                    last_xfer = cyc;
                end else stall_obs++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [L*DW-1:0] pack_a(input int t);
        logic [L*DW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = a_mem[t][i];
        return v;
    endfunction

    function automatic logic [L*DW-1:0] pack_b(input int t, input int c);
        logic [L*DW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = b_mem[t][c][i];
        return v;
    endfunction

    task automatic do_start(input int k, input int n);
        start = 1'b1;
        cfg_k = KW'(k);
        cfg_n = NW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_a(input int t, input bit gaps);
        int g = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        a_data = pack_a(t);
        a_valid = 1'b1;
        while (!a_ready && g < 200) begin @(negedge clk); g++; end
        if (!a_ready) begin chk("a_accept_timeout", a_ready, 1); a_valid = 1'b0; return; end
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input int t, input int c, input bit gaps);
        int g = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        b_data = pack_b(t, c);
        b_valid = 1'b1;
        while (!b_ready && g < 200) begin @(negedge clk); g++; end
        if (!b_ready) begin chk("b_accept_timeout", b_ready, 1); b_valid = 1'b0; return; end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        @(negedge clk);
        while (!done && g < 2000) begin @(negedge clk); g++; end
        chk("done_seen", done, 1);
        chk("done_after_last_c", cyc, last_xfer + 1);
        chk("c_all_delivered", exp_q.size(), 0);
        chk("busy_at_done", busy, 0);
        chk("err_at_done", err, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run(input int k, input int n, input bit gaps);
        for (int i = 0; i < MN; i++) got[i] = -999999999;
        exp_sat = 1'b0;
        model_run(k, n);
        do_start(k, n);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
        for (int t = 0; t < k; t++) begin
            send_a(t, gaps);
            for (int c = 0; c < n; c++) send_b(t, c, gaps);
        end
        wait_done();
`ifdef MVM_SAT_EN
        chk("sat_flag", sat_flag, exp_sat);
`endif
        tick();
    endtask

    task automatic err_start(input int k, input int n);
        do_start(k, n);
        @(negedge clk);
        chk("err_done_pulse", done, 1);
        chk("err_flag", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_done_low", done, 0);
        chk("err_sticky", err, 1);
        chk("err_busy_low", busy, 0);
        tick();
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_data", longint'(c_data), 0);
        chk("rst_c_idx", longint'(c_idx), 0);
    endtask

    task automatic set_s1();
        for (int i = 0; i < L; i++) begin
            a_mem[0][i] = 1;
            b_mem[0][0][i] = DW'(i + 1);
            b_mem[0][1][i] = -2;
        end
    endtask

    initial begin
        c_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        tick();

        set_s1();
        run(1, 2, 1'b0);
        chk("s1_c0", got[0], 36);
        chk("s1_c1", got[1], -16);

        for (int i = 0; i < L; i++) begin
            a_mem[0][i] = 2; a_mem[1][i] = 3;
            b_mem[0][0][i] = 1; b_mem[1][0][i] = 1;
        end
        run(2, 1, 1'b0);
        chk("s2_c0", got[0], 40);

        set_s1();
        stall_obs = 0;
        stall_cnt = 5;
        crdy_mode = 2;
        run(1, 2, 1'b0);
        chk("s3_c0", got[0], 36);
        chk("s3_c1", got[1], -16);
        chk("s3_stall_cycles", stall_obs, 5);

        crdy_mode = 1;
        run(1, 2, 1'b1);
        chk("s3_gaps_c0", got[0], 36);
        chk("s3_gaps_c1", got[1], -16);

        crdy_mode = 0;
        for (int i = 0; i < L; i++) begin a_mem[0][i] = 32767; b_mem[0][0][i] = 32767; end
        run(1, 1, 1'b0);
`ifdef MVM_SAT_EN
        chk("s4_sat_c0", got[0], 2147483647);
`else
        chk("s4_wrap_c0", got[0], -524280);
`endif

        err_start(1, 0);
        err_start(1, MN + 1);
        err_start(0, 2);
        set_s1();
        run(1, 2, 1'b0);
        chk("err_clear_c0", got[0], 36);

        do_start(1, 2);
        send_a(0, 1'b0);
        send_b(0, 0, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        tick();
        run(1, 2, 1'b0);
        chk("s6_c0", got[0], 36);
        chk("s6_c1", got[1], -16);

        crdy_mode = 1;
        for (int r = 0; r < 8; r++) begin
            int k, n;
            k = $urandom_range(1, 4);
            n = $urandom_range(1, 8);
            for (int t = 0; t < 4; t++)
                for (int i = 0; i < L; i++) begin
                    a_mem[t][i] = DW'($urandom);
                    for (int c = 0; c < 8; c++) b_mem[t][c][i] = DW'($urandom);
                end
            run(k, n, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
